uart_rx_to_axi_stream: RTL

Receive-side counterpart of the AXI-Stream-to-UART transmitter. It oversamples the serial `rx` line, recovers words framed exactly as the transmitter sends them, and packs `NUM_WORDS` consecutive words into one AXI-Stream beat of `W_OUT` bits. It sits directly downstream of the transmitter's `tx` line, either on the board or in loopback benches, and feeds the core's AXI-Stream sink.

---
 rtl/uart_rx_to_axi_stream_if.sv | 15 +
 rtl/uart_rx_to_axi_stream.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_to_axi_stream_if.sv
// Purpose: AXI-Stream beat channel carrying packed UART words to the sink.
// Signals:
//   m_data  - packed beat, first received word in the low bits
//   m_valid - beat available
//   m_ready - sink accepts the beat
interface uart_rx_to_axi_stream_if #(
  parameter int unsigned W_OUT = 16
);
  logic [W_OUT-1:0] m_data;
  logic             m_valid;
  logic             m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/uart_rx_to_axi_stream.sv
// Purpose: oversampling UART receiver that packs NUM_WORDS consecutive words
//          into one AXI-Stream beat of W_OUT bits.
// Ports:
//   clk       - single clock
//   rst       - synchronous active-high reset
//   rx        - asynchronous serial input, idle high
//   m_axis    - AXI-Stream master (m_data, m_valid, m_ready)
//   frame_err - one-cycle pulse when a stop bit is sampled low
//   overflow  - one-cycle pulse when a completed beat is dropped
module uart_rx_to_axi_stream #(
  parameter int unsigned CLOCKS_PER_PULSE = 4,
  parameter int unsigned BITS_PER_WORD    = 8,
  parameter int unsigned PACKET_SIZE      = BITS_PER_WORD + 5,
  parameter int unsigned W_OUT            = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx,
  uart_rx_to_axi_stream_if.master  m_axis,
  output logic                     frame_err,
  output logic                     overflow
);

  localparam int unsigned NUM_WORDS = W_OUT / BITS_PER_WORD;
  localparam int unsigned HALF      = CLOCKS_PER_PULSE / 2;
  localparam int unsigned CNT_W     = $clog2(CLOCKS_PER_PULSE);
  localparam int unsigned BIT_W     = $clog2(BITS_PER_WORD + 1);
  localparam int unsigned IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // Elaboration-time parameter sanity checks
  if (CLOCKS_PER_PULSE < 4 || (CLOCKS_PER_PULSE % 2) != 0) begin : g_bad_cpp
    $error("CLOCKS_PER_PULSE must be even and >= 4");
  end
  if ((W_OUT % BITS_PER_WORD) != 0 || NUM_WORDS < 1) begin : g_bad_wout
    $error("W_OUT must be a non-zero multiple of BITS_PER_WORD");
  end
  if (PACKET_SIZE < BITS_PER_WORD + 2) begin : g_bad_packet
    $error("PACKET_SIZE must leave room for at least one stop bit");
  end

  logic                     rx_meta_q, rx_meta_d;
  logic                     rx_s_q, rx_s_d;
  logic [1:0]               state_q, state_d;
  logic [CNT_W-1:0]         clk_cnt_q, clk_cnt_d;
  logic [BIT_W-1:0]         cnt_q, cnt_d;
  logic [BITS_PER_WORD-1:0] word_q, word_d;
  logic                     brk_q, brk_d;
  logic [W_OUT-1:0]         asm_q, asm_d;
  logic [IDX_W-1:0]         word_idx_q, word_idx_d;
  logic [W_OUT-1:0]         m_data_q, m_data_d;
  logic                     m_valid_q, m_valid_d;
  logic                     frame_err_q, frame_err_d;
  logic                     overflow_q, overflow_d;
  logic                     accept_c;
  logic [W_OUT-1:0]         beat_c;

  // Next-state, datapath and output logic
  always_comb begin
    rx_meta_d   = rx;
    rx_s_d      = rx_meta_q;
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q;
    cnt_d       = cnt_q;
    word_d      = word_q;
    brk_d       = brk_q;
    asm_d       = asm_q;
    word_idx_d  = word_idx_q;
    m_data_d    = m_data_q;
    m_valid_d   = m_valid_q;
    frame_err_d = 1'b0;
    overflow_d  = 1'b0;
    accept_c    = 1'b0;
    beat_c      = asm_q;

    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d   = S_START;
          clk_cnt_d = '0;
          cnt_d     = '0;
        end
      end
      S_START: begin
        if (clk_cnt_q == CNT_W'(HALF - 1)) begin
          clk_cnt_d = '0;
          state_d   = rx_s_q ? S_IDLE : S_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (clk_cnt_q == CNT_W'(CLOCKS_PER_PULSE - 1)) begin
          clk_cnt_d = '0;
          word_d    = {rx_s_q, word_q[BITS_PER_WORD-1:1]};
          if (cnt_q == BIT_W'(BITS_PER_WORD - 1)) begin
            state_d = S_STOP;
          end else begin
            cnt_d = cnt_q + BIT_W'(1);
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        // brk_q: stop bit was low; hold off re-arming until the line returns high
        if (brk_q) begin
          if (rx_s_q) begin
            brk_d   = 1'b0;
            state_d = S_IDLE;
          end
        end else if (clk_cnt_q == CNT_W'(CLOCKS_PER_PULSE - 1)) begin
          clk_cnt_d = '0;
          if (rx_s_q) begin
            accept_c = 1'b1;
            state_d  = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            brk_d       = 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    for (int unsigned i = 0; i < NUM_WORDS; i++) begin
      if (word_idx_q == IDX_W'(i)) begin
        beat_c[i*BITS_PER_WORD +: BITS_PER_WORD] = word_q;
      end
    end

    if (m_valid_q && m_axis.m_ready) begin
      m_valid_d = 1'b0;
    end

    // A completing beat may load in the same cycle the held beat is taken
    if (accept_c) begin
      asm_d = beat_c;
      if (word_idx_q == IDX_W'(NUM_WORDS - 1)) begin
        word_idx_d = '0;
        if (!m_valid_q || m_axis.m_ready) begin
          m_data_d  = beat_c;
          m_valid_d = 1'b1;
        end else begin
          overflow_d = 1'b1;
        end
      end else begin
        word_idx_d = word_idx_q + IDX_W'(1);
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= S_IDLE;
      clk_cnt_q   <= '0;
      cnt_q       <= '0;
      word_q      <= '0;
      brk_q       <= 1'b0;
      asm_q       <= '0;
      word_idx_q  <= '0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      rx_meta_q   <= rx_meta_d;
      rx_s_q      <= rx_s_d;
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      cnt_q       <= cnt_d;
      word_q      <= word_d;
      brk_q       <= brk_d;
      asm_q       <= asm_d;
      word_idx_q  <= word_idx_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
    end
  end

  assign m_axis.m_data  = m_data_q;
  assign m_axis.m_valid = m_valid_q;
  assign frame_err      = frame_err_q;
  assign overflow       = overflow_q;

endmodule
